gray_arbiter: RTL and testbench

- Shares one 3-bit Gray step counter between two requesters, A and B.
- Each requester asks for a number of counter steps. The block picks a requester by round-robin, then drives the counter's enable for exactly that many cycles and signals completion.
- The counter's sticky Overflow flag aborts the service. The block clears the counter and reports an error to the granted requester.
- The block sits between the requesters and the counter. It owns the counter's En and Reset inputs.

---
 rtl/gray_pkg.sv | 19 +
 rtl/rr_arb2.sv | 22 ++
 rtl/gray_arbiter.sv | 128 ++++++++++++
 tb/tb_gray_arbiter.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gray_pkg.sv
// gray_pkg: shared definitions for the Gray-counter arbiter.
//   state_e     - controller FSM states (IDLE, RUN, CLEAR, DONE)
//   REQ_A/REQ_B - requester IDs, used for the round-robin Last register
//   DEF_STEP_W  - default width of the step-count request fields
package gray_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      CLEAR = 2'd2,
      DONE  = 2'd3
   } state_e;

   localparam logic REQ_A = 1'b0;
   localparam logic REQ_B = 1'b1;

   localparam int DEF_STEP_W = 3;

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: combinational two-way round-robin picker.
//   ReqA/ReqB - requests
//   Last      - requester served last (REQ_A / REQ_B)
//   PickA/B   - one-hot pick, at most one high
//   Valid     - some request present
module rr_arb2
   import gray_pkg::*;
(
   input  logic ReqA,
   input  logic ReqB,
   input  logic Last,
   output logic PickA,
   output logic PickB,
   output logic Valid
);

   // On a tie the requester not served last wins.
   assign PickA = ReqA & (~ReqB | (Last == REQ_B));
   assign PickB = ReqB & (~ReqA | (Last == REQ_A));
   assign Valid = ReqA | ReqB;

endmodule

// File: rtl/gray_arbiter.sv
// gray_arbiter: shares one external 3-bit Gray step counter between two
// requesters. Picks a requester round-robin, enables the counter for the
// requested number of steps, then pulses Done. A sticky counter overflow
// aborts the service: the counter is cleared and Err is reported with Done.
//   Clk, Reset        - clock, synchronous active-high reset
//   ReqA/B, StepsA/B  - requests and step counts (held until Done)
//   GntA/B            - registered grant, high from first RUN cycle to DONE
//   DoneA/B, ErrA/B   - one-cycle completion pulse and abort flag
//   Busy              - controller not IDLE
//   CntEn, CntClr     - counter En / Reset
//   CntOverflow       - counter sticky Overflow
module gray_arbiter
   import gray_pkg::*;
#(
   parameter int STEP_W = DEF_STEP_W
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              ReqA,
   input  logic [STEP_W-1:0] StepsA,
   input  logic              ReqB,
   input  logic [STEP_W-1:0] StepsB,
   output logic              GntA,
   output logic              GntB,
   output logic              DoneA,
   output logic              DoneB,
   output logic              ErrA,
   output logic              ErrB,
   output logic              Busy,
   output logic              CntEn,
   output logic              CntClr,
   input  logic              CntOverflow
);

   state_e            state_q, state_d;
   logic [STEP_W-1:0] rem_q, rem_d;
   logic              err_q, err_d;
   logic              last_q, last_d;
   logic              gnt_a_q, gnt_a_d;
   logic              gnt_b_q, gnt_b_d;
   logic              en_d;
   logic              pick_a, pick_b, req_vld;

   rr_arb2 u_arb (
      .ReqA  (ReqA),
      .ReqB  (ReqB),
      .Last  (last_q),
      .PickA (pick_a),
      .PickB (pick_b),
      .Valid (req_vld)
   );

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      err_d   = err_q;
      last_d  = last_q;
      gnt_a_d = gnt_a_q;
      gnt_b_d = gnt_b_q;
      en_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (req_vld) begin
               state_d = RUN;
               gnt_a_d = pick_a;
               gnt_b_d = pick_b;
               rem_d   = pick_a ? StepsA : StepsB;
               err_d   = 1'b0;
               last_d  = pick_a ? REQ_A : REQ_B;
            end
         end
         RUN: begin
            // Overflow takes priority so an abort is always reported.
            if (CntOverflow) begin
               state_d = CLEAR;
               err_d   = 1'b1;
            end else if (rem_q == '0) begin
               state_d = DONE;
            end else begin
               // Guarded by rem_q != 0, so the decrement never wraps.
               en_d  = 1'b1;
               rem_d = rem_q - 1'b1;
            end
         end
         CLEAR: begin
            state_d = DONE;
            rem_d   = '0;   // unissued steps are discarded
         end
         DONE: begin
            state_d = IDLE;
            gnt_a_d = 1'b0;
            gnt_b_d = 1'b0;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q <= IDLE;
         rem_q   <= '0;
         err_q   <= 1'b0;
         last_q  <= REQ_B;
         gnt_a_q <= 1'b0;
         gnt_b_q <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         err_q   <= err_d;
         last_q  <= last_d;
         gnt_a_q <= gnt_a_d;
         gnt_b_q <= gnt_b_d;
      end
   end

   // Outputs are masked during Reset so an interrupted service gives no
   // enable and no Done pulse in the reset cycle.
   assign CntEn  = en_d & ~Reset;
   assign CntClr = Reset | (state_q == CLEAR);
   assign Busy   = (state_q != IDLE);
   assign GntA   = gnt_a_q;
   assign GntB   = gnt_b_q;
   assign DoneA  = (state_q == DONE) & gnt_a_q & ~Reset;
   assign DoneB  = (state_q == DONE) & gnt_b_q & ~Reset;
   assign ErrA   = DoneA & err_q;
   assign ErrB   = DoneB & err_q;

endmodule

// File: tb/tb_gray_arbiter.sv
module tb_gray_arbiter;

   logic       Clk = 1'b0;
   logic       Reset = 1'b0;
   logic       ReqA = 1'b0, ReqB = 1'b0;
   logic [2:0] StepsA = '0, StepsB = '0;
   logic       GntA, GntB, DoneA, DoneB, ErrA, ErrB, Busy;
   logic       CntEn, CntClr, CntOverflow;

   int checks = 0;
   int errors = 0;

   always #5 Clk = ~Clk;

   gray_arbiter #(.STEP_W(3)) dut (
      .Clk(Clk), .Reset(Reset),
      .ReqA(ReqA), .StepsA(StepsA), .ReqB(ReqB), .StepsB(StepsB),
      .GntA(GntA), .GntB(GntB), .DoneA(DoneA), .DoneB(DoneB),
      .ErrA(ErrA), .ErrB(ErrB), .Busy(Busy),
      .CntEn(CntEn), .CntClr(CntClr), .CntOverflow(CntOverflow)
   );

   // 3-bit Gray step counter with sticky overflow, flag visible the cycle
   // after the wrapping enable.
   logic [2:0] bin_q = '0;
   logic       ovf_q = 1'b0;
   logic [2:0] cnt_out;
   assign cnt_out     = bin_q ^ (bin_q >> 1);
   assign CntOverflow = ovf_q;
   always @(posedge Clk) begin
      if (CntClr) begin
         bin_q <= '0;
         ovf_q <= 1'b0;
      end else if (CntEn) begin
         bin_q <= bin_q + 3'd1;
         if (bin_q == 3'd7) ovf_q <= 1'b1;
      end
   end

   // Observation record filled by watch().
   int en_count, first_en, clr_count, clr_cyc;
   int doneA_cnt, doneA_cyc, doneA_cyc2, doneB_cnt, doneB_cyc, doneB_cyc2;
   int gntA_n, gntB_n;
   bit errA_d, errB_d;

   // Steps n cycles, sampling at each negedge (cycle 1 = first after the
   // request edge). With drop set, a requester releases Req on its Done.
   task automatic watch(input int n, input bit drop);
      en_count = 0; first_en = -1; clr_count = 0; clr_cyc = -1;
      doneA_cnt = 0; doneA_cyc = -1; doneA_cyc2 = -1;
      doneB_cnt = 0; doneB_cyc = -1; doneB_cyc2 = -1;
      gntA_n = 0; gntB_n = 0; errA_d = 0; errB_d = 0;
      for (int c = 1; c <= n; c++) begin
         @(negedge Clk);
         if (CntEn) begin
            en_count++;
            if (first_en < 0) first_en = c;
         end
         if (CntClr) begin
            clr_count++;
            if (clr_cyc < 0) clr_cyc = c;
         end
         if (GntA) gntA_n++;
         if (GntB) gntB_n++;
         if (DoneA) begin
            doneA_cnt++;
            if (doneA_cyc < 0) doneA_cyc = c; else doneA_cyc2 = c;
            errA_d = errA_d | ErrA;
            if (drop) ReqA = 1'b0;
         end
         if (DoneB) begin
            doneB_cnt++;
            if (doneB_cyc < 0) doneB_cyc = c; else doneB_cyc2 = c;
            errB_d = errB_d | ErrB;
            if (drop) ReqB = 1'b0;
         end
      end
   endtask

   task automatic do_reset();
      @(negedge Clk);
      ReqA = 0; ReqB = 0;
      Reset = 1;
      @(negedge Clk);
      Reset = 0;
   endtask

   task automatic test_reset();
      @(negedge Clk);
      Reset = 1;
      @(negedge Clk);
      checks++;
      if (CntClr !== 1'b1) begin errors++; $display("FAIL reset_clr got=%b exp=1", CntClr); end
      Reset = 0;
      @(negedge Clk);
      checks++;
      if ({Busy, GntA, GntB, DoneA, DoneB, ErrA, ErrB, CntEn, CntClr} !== 9'b0) begin
         errors++;
         $display("FAIL reset_outs got=%b exp=000000000",
                  {Busy, GntA, GntB, DoneA, DoneB, ErrA, ErrB, CntEn, CntClr});
      end
      checks++;
      if (cnt_out !== 3'b000 || CntOverflow !== 1'b0) begin
         errors++; $display("FAIL reset_cnt got=%b/%b exp=000/0", cnt_out, CntOverflow);
      end
   endtask

   task automatic test_basic();
      do_reset();
      ReqA = 1; StepsA = 3;
      watch(8, 1);
      checks++;
      if (en_count != 3 || first_en != 1) begin
         errors++; $display("FAIL basic_en got=%0d@%0d exp=3@1", en_count, first_en);
      end
      checks++;
      if (doneA_cyc != 5 || doneA_cnt != 1 || errA_d !== 1'b0) begin
         errors++; $display("FAIL basic_done got=cyc%0d n%0d err%b exp=cyc5 n1 err0", doneA_cyc, doneA_cnt, errA_d);
      end
      checks++;
      if (gntA_n != 5 || gntB_n != 0) begin
         errors++; $display("FAIL basic_gnt got=A%0d B%0d exp=A5 B0", gntA_n, gntB_n);
      end
      checks++;
      if (cnt_out !== 3'b010 || Busy !== 1'b0) begin
         errors++; $display("FAIL basic_cnt got=%b busy%b exp=010 busy0", cnt_out, Busy);
      end
   endtask

   task automatic test_fair();
      do_reset();
      ReqA = 1; StepsA = 1; ReqB = 1; StepsB = 2;
      watch(12, 1);
      checks++;
      if (doneA_cyc != 3 || doneB_cyc != 8) begin
         errors++; $display("FAIL fair_tie1 got=A%0d B%0d exp=A3 B8", doneA_cyc, doneB_cyc);
      end
      checks++;
      if (en_count != 3) begin errors++; $display("FAIL fair_en1 got=%0d exp=3", en_count); end
      // A alone, so A becomes the last served.
      ReqA = 1; StepsA = 1;
      watch(5, 1);
      checks++;
      if (doneA_cyc != 3) begin errors++; $display("FAIL fair_solo got=%0d exp=3", doneA_cyc); end
      ReqA = 1; StepsA = 1; ReqB = 1; StepsB = 2;
      watch(12, 1);
      checks++;
      if (doneB_cyc != 4 || doneA_cyc != 8) begin
         errors++; $display("FAIL fair_tie2 got=B%0d A%0d exp=B4 A8", doneB_cyc, doneA_cyc);
      end
   endtask

   task automatic test_zero();
      do_reset();
      ReqB = 1; StepsB = 0;
      watch(5, 1);
      checks++;
      if (en_count != 0 || doneB_cyc != 2 || errB_d !== 1'b0) begin
         errors++; $display("FAIL zero got=en%0d done%0d err%b exp=en0 done2 err0", en_count, doneB_cyc, errB_d);
      end
      checks++;
      if (cnt_out !== 3'b000 || gntA_n != 0) begin
         errors++; $display("FAIL zero_cnt got=%b gntA%0d exp=000 gntA0", cnt_out, gntA_n);
      end
   endtask

   task automatic test_overflow();
      do_reset();
      ReqA = 1; StepsA = 7;
      watch(11, 1);
      checks++;
      if (doneA_cyc != 9 || cnt_out !== 3'b100 || CntOverflow !== 1'b0) begin
         errors++; $display("FAIL ovf_fill got=done%0d cnt%b ovf%b exp=done9 cnt100 ovf0", doneA_cyc, cnt_out, CntOverflow);
      end
      ReqA = 1; StepsA = 3;
      watch(8, 1);
      checks++;
      if (en_count != 1 || first_en != 1) begin
         errors++; $display("FAIL ovf_en got=%0d@%0d exp=1@1", en_count, first_en);
      end
      checks++;
      if (clr_count != 1 || clr_cyc != 3) begin
         errors++; $display("FAIL ovf_clr got=%0d@%0d exp=1@3", clr_count, clr_cyc);
      end
      checks++;
      if (doneA_cyc != 4 || errA_d !== 1'b1 || doneA_cnt != 1) begin
         errors++; $display("FAIL ovf_done got=cyc%0d err%b n%0d exp=cyc4 err1 n1", doneA_cyc, errA_d, doneA_cnt);
      end
      checks++;
      if (cnt_out !== 3'b000 || CntOverflow !== 1'b0) begin
         errors++; $display("FAIL ovf_after got=%b/%b exp=000/0", cnt_out, CntOverflow);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      ReqB = 1; StepsB = 5;
      @(negedge Clk);           // cycle 1
      Reset = 1;                // asserted during cycle 2
      @(negedge Clk);
      checks++;
      if (CntClr !== 1'b1 || CntEn !== 1'b0 || DoneB !== 1'b0) begin
         errors++; $display("FAIL mid_rstcyc got=clr%b en%b done%b exp=clr1 en0 done0", CntClr, CntEn, DoneB);
      end
      Reset = 0; ReqB = 0;
      watch(5, 1);
      checks++;
      if (gntB_n != 0 || doneB_cnt != 0 || Busy !== 1'b0 || cnt_out !== 3'b000) begin
         errors++; $display("FAIL mid_after got=gntB%0d doneB%0d busy%b cnt%b exp=0 0 0 000", gntB_n, doneB_cnt, Busy, cnt_out);
      end
      ReqA = 1; StepsA = 2;
      watch(6, 1);
      checks++;
      if (doneA_cyc != 4 || en_count != 2 || cnt_out !== 3'b011) begin
         errors++; $display("FAIL mid_next got=done%0d en%0d cnt%b exp=done4 en2 cnt011", doneA_cyc, en_count, cnt_out);
      end
   endtask

   task automatic test_rereq();
      do_reset();
      ReqA = 1; StepsA = 2;
      watch(9, 0);
      ReqA = 0;
      checks++;
      if (doneA_cnt != 2 || doneA_cyc != 4 || doneA_cyc2 != 9) begin
         errors++; $display("FAIL rereq_done got=n%0d %0d,%0d exp=n2 4,9", doneA_cnt, doneA_cyc, doneA_cyc2);
      end
      checks++;
      if (en_count != 4 || gntA_n != 8) begin
         errors++; $display("FAIL rereq_en got=en%0d gnt%0d exp=en4 gnt8", en_count, gntA_n);
      end
      watch(3, 1);
      checks++;
      if (Busy !== 1'b0 || doneA_cnt != 0 || cnt_out !== 3'b110) begin
         errors++; $display("FAIL rereq_end got=busy%b done%0d cnt%b exp=0 0 110", Busy, doneA_cnt, cnt_out);
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_fair();
      test_zero();
      test_overflow();
      test_reset_mid();
      test_rereq();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
